analog_seq_ctrl: RTL
====================

ANALOG_SEQ_CTRL -- requirements
Module: analog_seq_ctrl

Interface
REQ-001 SHALL have parameter synchronizer_pipe_depth, default 3: depth of the analog TX synchronizer being configured.
REQ-002 SHALL have parameter iter_bitwidth, default 16: width of the iteration count and iteration counter.
REQ-003 SHALL have parameter timeout_bitwidth, default 16: width of the watchdog limit and watchdog counter.
REQ-004 SHALL have clk_i  input  1: single clock; all logic is rising-edge.
REQ-005 SHALL have rst_ni  input  1: asynchronous, active-low reset.
REQ-006 SHALL have en_i  input  1: block enable; low forces return to IDLE.
REQ-007 SHALL have start_i  input  1: launch a run (sampled in IDLE/DONE/ERROR only).
REQ-008 SHALL have abort_i  input  1: abandon current run.
REQ-009 SHALL have cfg_iter_num_i  input  iter_bitwidth: number of anneal iterations.
REQ-010 SHALL have cfg_pipe_num_i  input  $clog2(synchronizer_pipe_depth): synchronizer stage select.
REQ-011 SHALL have cfg_mode_i  input  1: synchronizer mode (0 one-shot, 1 continuous).
REQ-012 SHALL have cfg_timeout_i  input  timeout_bitwidth: per-wait watchdog limit in cycles; 0 disables.
REQ-013 SHALL have tx_configure_enable_o  output  1: TX config load strobe.
REQ-014 SHALL have synchronizer_pipe_num_o  output  $clog2(synchronizer_pipe_depth): latched cfg_pipe_num.
REQ-015 SHALL have synchronizer_mode_o  output  1: latched cfg_mode.
REQ-016 SHALL have macro_start_o  output  1: one-cycle compute-start pulse to the analog macro.
REQ-017 SHALL have cmpt_finish_i  input  1: analog macro compute-finish level.
REQ-018 SHALL have spin_handshake_i  input  1: TX-to-digital spin_valid and spin_ready both high.
REQ-019 SHALL have busy_o  output  1; done_o  output  1 (one-cycle pulse); error_o  output  1 (sticky); iter_cnt_o  output  iter_bitwidth (completed iterations).

Function
REQ-020 SHALL implement the FSM states IDLE, CONFIG, START, WAIT_CMPT, WAIT_SPIN, DONE and ERROR.
REQ-021 SHALL, in IDLE/DONE/ERROR with start_i=1, latch all cfg_* inputs, clear iter_cnt_o, clear error_o, and enter CONFIG the next cycle.
REQ-022 SHALL, in CONFIG, assert tx_configure_enable_o for exactly one cycle with synchronizer_pipe_num_o and synchronizer_mode_o already holding the latched values; next state is DONE if cfg_iter_num==0, else START.
REQ-023 SHALL, in START, assert macro_start_o for exactly one cycle, then enter WAIT_CMPT.
REQ-024 SHALL leave WAIT_CMPT on the rising edge of cmpt_finish_i (registered previous value, so a level held high from before START does not qualify) and enter WAIT_SPIN.
REQ-025 SHALL, in WAIT_SPIN on spin_handshake_i, increment iter_cnt_o; if the new value equals cfg_iter_num it SHALL enter DONE, else START.
REQ-026 SHALL let spin_handshake_i in the same cycle as the cmpt_finish_i rise count only in WAIT_SPIN, never in WAIT_CMPT.
REQ-027 SHALL clear the watchdog on entry to WAIT_CMPT or WAIT_SPIN and increment it each cycle in those states; when cfg_timeout!=0 and the count reaches cfg_timeout with the exit condition absent, it SHALL enter ERROR and set error_o.
REQ-028 SHALL give the exit condition priority over the timeout when both occur in the same cycle.
REQ-029 SHALL saturate the watchdog counter at its maximum value without wrapping.
REQ-030 SHALL pulse done_o for exactly one cycle in DONE, then return to IDLE unless start_i is asserted.
REQ-031 SHALL have ERROR hold error_o=1 until start_i, and SHALL not return to IDLE otherwise.
REQ-032 SHALL, on abort_i or en_i=0 in any state, go to IDLE next cycle with error_o unchanged; abort_i SHALL take priority over start_i.
REQ-033 SHALL drive busy_o=1 in CONFIG, START, WAIT_CMPT and WAIT_SPIN.
REQ-034 SHALL keep iter_cnt_o holding its value after DONE, ERROR or abort until the next start.

Reset
REQ-035 SHALL, on rst_ni low, asynchronously place the FSM in IDLE; all outputs and counters SHALL be 0 except synchronizer_pipe_num_o, which SHALL reset to its maximum representable value, and the latched cfg_timeout, which SHALL reset to 0.

Structure
REQ-036 SHALL place the FSM state enum (3-bit encoding) in a shared package, analog_ctrl_pkg.
REQ-037 SHALL implement the watchdog as one sub-module, analog_seq_watchdog (clear, count-enable, limit, expired).
REQ-038 SHALL build all registers with the codebase register macros.

Verification
REQ-039 SHALL cover: iter=3, mode=1, pipe=2, finish rises 5 cycles after each start, handshake 2 cycles later -> exactly 3 macro_start_o pulses, one config strobe carrying 2/1, done_o once, iter_cnt_o=3.
REQ-040 SHALL cover: iter=0 -> config strobe, then done_o the next cycle, and no macro_start_o.
REQ-041 SHALL cover: timeout=4, finish never rises -> error_o=1 on the 4th WAIT_CMPT cycle, busy_o=0, and the state is held until start_i.
REQ-042 SHALL cover: timeout=4, finish rises on the same cycle the count reaches 4 -> no error, and the FSM enters WAIT_SPIN.
REQ-043 SHALL cover: abort_i during WAIT_SPIN at iter_cnt=1 -> IDLE next cycle, iter_cnt_o=1, no done_o.
REQ-044 SHALL cover: cmpt_finish_i held high across START -> no advance until it falls and rises again; rst_ni asserted mid-run -> all outputs return immediately to their reset values.

Source files
------------

// File: rtl/analog_ctrl_pkg.sv
// Shared types and helpers for the analog sequencing controller.
package analog_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CONFIG    = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_CMPT = 3'd3,
    ST_WAIT_SPIN = 3'd4,
    ST_DONE      = 3'd5,
    ST_ERROR     = 3'd6
  } seq_state_e;

  // States in which a run is in flight.
  function automatic logic is_busy(input seq_state_e s);
    return (s == ST_CONFIG) || (s == ST_START) ||
           (s == ST_WAIT_CMPT) || (s == ST_WAIT_SPIN);
  endfunction

  // States guarded by the watchdog.
  function automatic logic is_wait(input seq_state_e s);
    return (s == ST_WAIT_CMPT) || (s == ST_WAIT_SPIN);
  endfunction

  // States in which start_i launches a new run.
  function automatic logic accepts_start(input seq_state_e s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/analog_seq_watchdog.sv
// Per-wait watchdog: saturating cycle counter compared against a limit.
// expired_o flags the cycle in which the count (including the current
// cycle) reaches the limit; a zero limit disables it.
module analog_seq_watchdog #(
  parameter int unsigned cnt_width = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 count_en_i,
  input  logic [cnt_width-1:0] limit_i,
  output logic                 expired_o
);

  logic [cnt_width-1:0] cnt_q, cnt_d;
  logic [cnt_width:0]   cnt_now;

  // Next count: clear wins, otherwise increment and hold at all-ones.
  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d (no latch).
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + cnt_width'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      cnt_q <= cnt_d;
    end
  end

  // One extra bit keeps the +1 from wrapping when the counter is saturated.
  assign cnt_now   = {1'b0, cnt_q} + (cnt_width + 1)'(1);
  assign expired_o = count_en_i && (limit_i != '0) && (cnt_now >= {1'b0, limit_i});

endmodule

// File: rtl/analog_seq_ctrl.sv
// Sequencer for the analog annealer: configures the TX synchronizer, then
// runs cfg_iter_num compute/spin-handshake iterations with a watchdog on
// each wait, reporting done/error and the completed iteration count.
module analog_seq_ctrl
  import analog_ctrl_pkg::*;
#(
  parameter int unsigned synchronizer_pipe_depth = 3,
  parameter int unsigned iter_bitwidth           = 16,
  parameter int unsigned timeout_bitwidth        = 16
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic                                       en_i,
  input  logic                                       start_i,
  input  logic                                       abort_i,
  input  logic [iter_bitwidth-1:0]                   cfg_iter_num_i,
  input  logic [$clog2(synchronizer_pipe_depth)-1:0] cfg_pipe_num_i,
  input  logic                                       cfg_mode_i,
  input  logic [timeout_bitwidth-1:0]                cfg_timeout_i,
  output logic                                       tx_configure_enable_o,
  output logic [$clog2(synchronizer_pipe_depth)-1:0] synchronizer_pipe_num_o,
  output logic                                       synchronizer_mode_o,
  output logic                                       macro_start_o,
  input  logic                                       cmpt_finish_i,
  input  logic                                       spin_handshake_i,
  output logic                                       busy_o,
  output logic                                       done_o,
  output logic                                       error_o,
  output logic [iter_bitwidth-1:0]                   iter_cnt_o
);

  localparam int unsigned PipeW = $clog2(synchronizer_pipe_depth);

  seq_state_e                  state_q, state_d;
  logic [iter_bitwidth-1:0]    iter_cnt_q, iter_cnt_d, iter_cnt_inc;
  logic [iter_bitwidth-1:0]    cfg_iter_q;
  logic [PipeW-1:0]            cfg_pipe_q;
  logic                        cfg_mode_q;
  logic [timeout_bitwidth-1:0] cfg_timeout_q;
  logic                        error_q, error_d;
  logic                        cmpt_prev_q;
  logic                        cmpt_rise;
  logic                        load_cfg;
  logic                        wd_clear, wd_count, wd_expired;

  // Only a fresh low-to-high finish counts; a level left high does not.
  assign cmpt_rise    = cmpt_finish_i & ~cmpt_prev_q;
  assign iter_cnt_inc = iter_cnt_q + iter_bitwidth'(1);

  // Next state, iteration count, error flag and config-load decision.
  always_comb begin
    state_d    = state_q;
    iter_cnt_d = iter_cnt_q;
    error_d    = error_q;
    load_cfg   = 1'b0;
    if (abort_i || !en_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start_i) begin
            load_cfg   = 1'b1;
            iter_cnt_d = '0;
            error_d    = 1'b0;
            state_d    = ST_CONFIG;
          end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
          end
        end
        ST_CONFIG:    state_d = (cfg_iter_q == '0) ? ST_DONE : ST_START;
        ST_START:     state_d = ST_WAIT_CMPT;
        ST_WAIT_CMPT: begin
          // Handshake is deliberately ignored here; it only counts in WAIT_SPIN.
          if (cmpt_rise) begin
            state_d = ST_WAIT_SPIN;
          end else if (wd_expired) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end
        end
        ST_WAIT_SPIN: begin
          if (spin_handshake_i) begin
            iter_cnt_d = iter_cnt_inc;
            state_d    = (iter_cnt_inc == cfg_iter_q) ? ST_DONE : ST_START;
          end else if (wd_expired) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Watchdog restarts on every entry into a wait state.
  assign wd_count = is_wait(state_q);
  assign wd_clear = is_wait(state_d) && (state_d != state_q);

  analog_seq_watchdog #(
    .cnt_width (timeout_bitwidth)
  ) u_watchdog (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (wd_clear),
    .count_en_i (wd_count),
    .limit_i    (cfg_timeout_q),
    .expired_o  (wd_expired)
  );

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Iteration counter, sticky error, finish history and latched configuration.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      iter_cnt_q    <= '0;
      error_q       <= 1'b0;
      cmpt_prev_q   <= 1'b0;
      cfg_iter_q    <= '0;
      cfg_pipe_q    <= '1;
      cfg_mode_q    <= 1'b0;
      cfg_timeout_q <= '0;
    end else begin
      iter_cnt_q  <= iter_cnt_d;
      error_q     <= error_d;
      cmpt_prev_q <= cmpt_finish_i;
      if (load_cfg) begin
        cfg_iter_q    <= cfg_iter_num_i;
        cfg_pipe_q    <= cfg_pipe_num_i;
        cfg_mode_q    <= cfg_mode_i;
        cfg_timeout_q <= cfg_timeout_i;
      end
    end
  end

  assign tx_configure_enable_o   = (state_q == ST_CONFIG);
  assign macro_start_o           = (state_q == ST_START);
  assign done_o                  = (state_q == ST_DONE);
  assign busy_o                  = is_busy(state_q);
  assign error_o                 = error_q;
  assign iter_cnt_o              = iter_cnt_q;
  assign synchronizer_pipe_num_o = cfg_pipe_q;
  assign synchronizer_mode_o     = cfg_mode_q;

endmodule
